// File: rtl/idct_ft.sv
// idct_ft: 1-D 8-point integer inverse DCT, one row per cycle, fixed 8-cycle latency.
// Define IDCT_FT_SAT_EN to clamp outputs to [0, 2^W_O-1]; otherwise outputs wrap mod 2^W_O.
module idct_ft #(
  parameter int unsigned W_O = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [7:0][15:0] in_data,
  input  logic                    in_eob,
  input  logic                    in_sob,
  input  logic                    in_sof,
  output logic                    out_valid,
  output logic [7:0][W_O-1:0]     out_data,
  output logic                    out_eob,
  output logic                    out_sob,
  output logic                    out_sof
);

`ifdef IDCT_FT_SAT_EN
  localparam int unsigned ZW = 32;
  localparam logic signed [31:0] MAXV = (32'sd1 <<< W_O) - 32'sd1;
`else
  localparam int unsigned ZW = W_O;
`endif
  localparam logic signed [31:0] LVL = 32'sd1 <<< (W_O - 1);

  // A(n,k) from the cosine quarter-wave table: fold the angle index (2n+1)k mod 32 into 0..8.
  function automatic logic signed [31:0] coef(input int unsigned n, input int unsigned k);
    int unsigned        m;
    logic               neg;
    logic signed [31:0] mag;
    m = ((2 * n + 1) * k) % 32;
    if (m > 16) m = 32 - m;
    neg = (m > 8);
    if (neg) m = 16 - m;
    case (m)
      0:       mag = (k == 0) ? 32'sd1448 : 32'sd2048;
      1:       mag = 32'sd2009;
      2:       mag = 32'sd1892;
      3:       mag = 32'sd1703;
      4:       mag = 32'sd1448;
      5:       mag = 32'sd1138;
      6:       mag = 32'sd784;
      7:       mag = 32'sd400;
      default: mag = 32'sd0;
    endcase
    return neg ? -mag : mag;
  endfunction

  logic signed [15:0]   x_q    [8];
  logic signed [15:0]   x_d    [8];
  logic signed [31:0]   prod_q [8][8];
  logic signed [31:0]   prod_d [8][8];
  logic signed [31:0]   s4_q   [8][4];
  logic signed [31:0]   s4_d   [8][4];
  logic signed [31:0]   s2_q   [8][2];
  logic signed [31:0]   s2_d   [8][2];
  logic signed [31:0]   s1_q   [8];
  logic signed [31:0]   s1_d   [8];
  logic signed [31:0]   y_q    [8];
  logic signed [31:0]   y_d    [8];
  logic signed [ZW-1:0] z_q    [8];
  logic signed [ZW-1:0] z_d    [8];
  logic [7:0][W_O-1:0]  out_q, out_d;
  logic [7:0]           vld_q, vld_d, eob_q, eob_d, sob_q, sob_d, sof_q, sof_d;

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) x_d[k] = $signed(in_data[k]);
    for (int unsigned n = 0; n < 8; n++) begin
      for (int unsigned k = 0; k < 8; k++) prod_d[n][k] = 32'(x_q[k]) * coef(n, k);
      for (int unsigned j = 0; j < 4; j++) s4_d[n][j] = prod_q[n][2*j] + prod_q[n][2*j+1];
      for (int unsigned j = 0; j < 2; j++) s2_d[n][j] = s4_q[n][2*j] + s4_q[n][2*j+1];
      s1_d[n] = s2_q[n][0] + s2_q[n][1];
      y_d[n]  = (s1_q[n] + 32'sd2048) >>> 12;
      z_d[n]  = ZW'(y_q[n] + LVL);
`ifdef IDCT_FT_SAT_EN
      if (z_q[n] < 0)         out_d[n] = '0;
      else if (z_q[n] > MAXV) out_d[n] = '1;
      else                    out_d[n] = z_q[n][W_O-1:0];
`else
      out_d[n] = z_q[n];
`endif
    end
    // Sideband shifts alongside the 8 data stages, independent of in_valid.
    vld_d = {vld_q[6:0], in_valid};
    eob_d = {eob_q[6:0], in_eob};
    sob_d = {sob_q[6:0], in_sob};
    sof_d = {sof_q[6:0], in_sof};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '{default: '0};
      prod_q <= '{default: '0};
      s4_q   <= '{default: '0};
      s2_q   <= '{default: '0};
      s1_q   <= '{default: '0};
      y_q    <= '{default: '0};
      z_q    <= '{default: '0};
      out_q  <= '0;
      vld_q  <= '0;
      eob_q  <= '0;
      sob_q  <= '0;
      sof_q  <= '0;
    end else begin
      x_q    <= x_d;
      prod_q <= prod_d;
      s4_q   <= s4_d;
      s2_q   <= s2_d;
      s1_q   <= s1_d;
      y_q    <= y_d;
      z_q    <= z_d;
      out_q  <= out_d;
      vld_q  <= vld_d;
      eob_q  <= eob_d;
      sob_q  <= sob_d;
      sof_q  <= sof_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = vld_q[7];
  assign out_eob   = eob_q[7];
  assign out_sob   = sob_q[7];
  assign out_sof   = sof_q[7];

endmodule

// File: tb/tb_idct_ft.sv
// tb_idct_ft: self-checking bench for idct_ft; reference IDCT built from real-valued cosines,
// honouring IDCT_FT_SAT_EN the same way as the design build.
module tb_idct_ft;
  localparam int unsigned W_O   = 8;
  localparam int          DEPTH = 1024;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid, in_eob, in_sob, in_sof;
  logic signed [7:0][15:0] in_data;
  logic                    out_valid, out_eob, out_sob, out_sof;
  logic [7:0][W_O-1:0]     out_data;

  idct_ft #(.W_O(W_O)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data),
    .in_eob(in_eob), .in_sob(in_sob), .in_sof(in_sof),
    .out_valid(out_valid), .out_data(out_data),
    .out_eob(out_eob), .out_sob(out_sob), .out_sof(out_sof)
  );

  always #5 clk = ~clk;

  int                 n_chk = 0;
  int                 n_fail = 0;
  int                 cyc = 0;
  int                 a_tab [8][8];
  logic signed [15:0] xin [8];
  // Expected output for the row driven in cycle c appears at cycle c+8.
  bit                 e_v [DEPTH], e_eob [DEPTH], e_sob [DEPTH], e_sof [DEPTH];
  int                 e_d [DEPTH][8];

  task automatic build_a();
    real r, ck;
    for (int n = 0; n < 8; n++)
      for (int k = 0; k < 8; k++) begin
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        r  = 4096.0 * ck / 2.0 * $cos(real'((2*n+1)*k) * 3.14159265358979323846 / 16.0);
        a_tab[n][k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
      end
  endtask

  // Drive one cycle of inputs, record what the reference says should emerge, advance one clock.
  task automatic step(input bit v, input bit eob, input bit sob, input bit sof);
    longint s, z;
    in_valid = v; in_eob = eob; in_sob = sob; in_sof = sof;
    for (int k = 0; k < 8; k++) in_data[k] = xin[k];
    if (cyc < DEPTH) begin
      e_v[cyc] = v && !rst; e_eob[cyc] = eob && !rst;
      e_sob[cyc] = sob && !rst; e_sof[cyc] = sof && !rst;
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += longint'(xin[k]) * longint'(a_tab[n][k]);
        z = ((s + 2048) >>> 12) + (longint'(1) << (W_O - 1));
`ifdef IDCT_FT_SAT_EN
        if (z < 0) z = 0;
        else if (z > (longint'(1) << W_O) - 1) z = (longint'(1) << W_O) - 1;
`else
        z = ((z % (longint'(1) << W_O)) + (longint'(1) << W_O)) % (longint'(1) << W_O);
`endif
        e_d[cyc][n] = int'(z);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) xin[k] = 16'sd1234;
    step(1, 1, 1, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_chk++; if (out_eob !== 1'b0) begin n_fail++; $display("FAIL reset_eob: got %b expected 0", out_eob); end
    n_chk++; if (out_sob !== 1'b0) begin n_fail++; $display("FAIL reset_sob: got %b expected 0", out_sob); end
    n_chk++; if (out_sof !== 1'b0) begin n_fail++; $display("FAIL reset_sof: got %b expected 0", out_sof); end
    n_chk++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
    rst = 1'b0;
    for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
  endtask

  // Single rows with only the DC term set; value and 8-cycle latency are both checked.
  task automatic test_directed();
    int x0 [3];
    int want [3];
    x0 = '{0, 100, -1000};
`ifdef IDCT_FT_SAT_EN
    want = '{128, 163, 0};
`else
    want = '{128, 163, 30};
`endif
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
      xin[0] = 16'(x0[t]);
      step(1, 0, 0, 0);
      for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
      for (int i = 2; i <= 9; i++) begin
        step(0, 0, 0, 0);
        n_chk++;
        if (out_valid !== (i == 8)) begin
          n_fail++; $display("FAIL dc%0d_latency edge %0d: got valid %b expected %b", t, i, out_valid, i == 8);
        end
        if (i == 8)
          for (int n = 0; n < 8; n++) begin
            n_chk++;
            if (out_data[n] !== W_O'(want[t])) begin
              n_fail++; $display("FAIL dc%0d_data[%0d]: got %0d expected %0d", t, n, out_data[n], want[t]);
            end
          end
      end
    end
  endtask

  task automatic test_back_to_back();
    int j;
    for (int i = 0; i < 72; i++) begin
      j = cyc - 8;
      n_chk++;
      if ({out_valid, out_eob, out_sob, out_sof} !== {e_v[j], e_eob[j], e_sob[j], e_sof[j]}) begin
        n_fail++; $display("FAIL b2b_ctl cyc %0d: got %b expected %b", cyc,
          {out_valid, out_eob, out_sob, out_sof}, {e_v[j], e_eob[j], e_sob[j], e_sof[j]});
      end
      if (e_v[j])
        for (int n = 0; n < 8; n++) begin
          n_chk++;
          if (out_data[n] !== W_O'(e_d[j][n])) begin
            n_fail++; $display("FAIL b2b_data cyc %0d n %0d: got %0d expected %0d", cyc, n, out_data[n], e_d[j][n]);
          end
        end
      if (i < 64) begin
        for (int k = 0; k < 8; k++)
          case ($urandom_range(0, 9))
            0:       xin[k] = 16'sh7fff;
            1:       xin[k] = -16'sh8000;
            default: xin[k] = 16'($urandom);
          endcase
        step(1, (i % 8) == 7, (i % 8) == 0, i == 0);
      end else begin
        for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
        step(0, 0, 0, 0);
      end
    end
  endtask

  // Alternating cadence; idle cycles carry random data and flags that must still pass through.
  task automatic test_alternating();
    int j;
    for (int i = 0; i < 26; i++) begin
      j = cyc - 8;
      n_chk++;
      if ({out_valid, out_eob, out_sob, out_sof} !== {e_v[j], e_eob[j], e_sob[j], e_sof[j]}) begin
        n_fail++; $display("FAIL alt_ctl cyc %0d: got %b expected %b", cyc,
          {out_valid, out_eob, out_sob, out_sof}, {e_v[j], e_eob[j], e_sob[j], e_sof[j]});
      end
      if (e_v[j]) begin
        for (int n = 0; n < 8; n++) begin
          n_chk++;
          if (out_data[n] !== W_O'(e_d[j][n])) begin
            n_fail++; $display("FAIL alt_data cyc %0d n %0d: got %0d expected %0d", cyc, n, out_data[n], e_d[j][n]);
          end
        end
`ifdef IDCT_FT_SAT_EN
        n_chk++;
        if (out_data[0] !== 8'd255 || out_data[7] !== 8'd0) begin
          n_fail++; $display("FAIL alt_sat cyc %0d: got %0d/%0d expected 255/0", cyc, out_data[0], out_data[7]);
        end
`endif
      end
      if (i < 18 && (i % 2) == 0) begin
        for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
        xin[1] = 16'sh7fff;
        step(1, 0, 0, 0);
      end else begin
        for (int k = 0; k < 8; k++) xin[k] = 16'($urandom);
        step(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  task automatic test_reset_midstream();
    int j, r, seen;
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 8; k++) xin[k] = 16'($urandom);
      step(i < 4, i == 3, i == 0, i == 0);
      n_chk++;
      if (out_valid !== e_v[cyc-8]) begin
        n_fail++; $display("FAIL mid_pre cyc %0d: got valid %b expected %b", cyc, out_valid, e_v[cyc-8]);
      end
    end
    // Reset discards every row that has not yet emerged.
    r = cyc;
    for (int c = r - 8; c < r; c++) begin e_v[c] = 0; e_eob[c] = 0; e_sob[c] = 0; e_sof[c] = 0; end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({out_valid, out_eob, out_sob, out_sof} !== 4'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL mid_async_clear: got ctl %b data %h expected 0", {out_valid, out_eob, out_sob, out_sof}, out_data);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) xin[k] = 16'($urandom);
    step(1, 1, 1, 0);
    for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
    seen = 0;
    for (int e = 2; e <= 12; e++) begin
      j = cyc - 8;
      n_chk++;
      if ({out_valid, out_eob, out_sob, out_sof} !== {e_v[j], e_eob[j], e_sob[j], e_sof[j]}) begin
        n_fail++; $display("FAIL mid_ctl cyc %0d: got %b expected %b", cyc,
          {out_valid, out_eob, out_sob, out_sof}, {e_v[j], e_eob[j], e_sob[j], e_sof[j]});
      end
      if (out_valid === 1'b1 && seen == 0) seen = e - 1;
      if (e_v[j])
        for (int n = 0; n < 8; n++) begin
          n_chk++;
          if (out_data[n] !== W_O'(e_d[j][n])) begin
            n_fail++; $display("FAIL mid_data n %0d: got %0d expected %0d", n, out_data[n], e_d[j][n]);
          end
        end
      step(0, 0, 0, 0);
    end
    n_chk++;
    if (seen != 8) begin
      n_fail++; $display("FAIL mid_latency: got %0d edges expected 8 (0 = never within bound)", seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_eob = 1'b0; in_sob = 1'b0; in_sof = 1'b0;
    in_data = '0;
    for (int k = 0; k < 8; k++) xin[k] = 16'sd0;
    build_a();
    test_reset();
    test_directed();
    test_back_to_back();
    test_alternating();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
